// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order front end: the decoded
// instruction-buffer entry layout plus fetch/dispatch widths.
package ooo_pkg;

  localparam int FETCH_W    = 4;
  localparam int DISPATCH_W = 2;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rt;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       op_a_local_dep;
    logic [3:0] op_a_owner;
    logic       op_b_local_dep;
    logic [3:0] op_b_owner;
    logic       uses_rb;
    logic       is_ld_str;
    logic       is_fxu;
    logic       is_branch;
  } ibuf_entry_t;

  localparam int IBUF_ENTRY_W = $bits(ibuf_entry_t);

  // Opcode classes as seen by dispatch
  localparam logic [3:0] OP_CLASS_ALU    = 4'h0;
  localparam logic [3:0] OP_CLASS_LOAD   = 4'h8;
  localparam logic [3:0] OP_CLASS_STORE  = 4'h9;
  localparam logic [3:0] OP_CLASS_BRANCH = 4'hC;

endpackage

// File: rtl/ibuf_ram.sv
// Entry storage for instr_buffer: multi-write, combinational-read register
// array addressed by already-wrapped indices.
module ibuf_ram
  import ooo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 4,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic [WR_PORTS-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   waddr [0:WR_PORTS-1],
  input  logic [IBUF_ENTRY_W-1:0]    wdata [0:WR_PORTS-1],
  input  logic [$clog2(DEPTH)-1:0]   raddr [0:RD_PORTS-1],
  output logic [IBUF_ENTRY_W-1:0]    rdata [0:RD_PORTS-1]
);

  logic [IBUF_ENTRY_W-1:0] mem [0:DEPTH-1];

  // Write addresses are consecutive slots, so enabled ports never collide
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (we[i]) mem[waddr[i]] <= wdata[i];
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between decode and dispatch.
// Optional IBUF_STATS_EN adds the full_stall_cycles counter output.
module instr_buffer
  import ooo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 4,
  parameter int DEQ_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [2:0]              enq_count,
  input  logic [IBUF_ENTRY_W-1:0] enq_entry [0:ENQ_W-1],
  output logic [2:0]              free_slots,
  output logic                    out_valid [0:DEQ_W-1],
  output logic [IBUF_ENTRY_W-1:0] out_entry [0:DEQ_W-1],
  input  logic [1:0]              deq_count,
  output logic                    overflow_err,
  output logic                    underflow_err
`ifdef IBUF_STATS_EN
  ,
  output logic [15:0]             full_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]        head, tail;
  logic [OCC_W-1:0]        occupancy, room, occ_next;
  logic [2:0]              accepted;
  logic [1:0]              valid_lanes, consumed;
  logic [ENQ_W-1:0]        we;
  logic [PTR_W-1:0]        waddr [0:ENQ_W-1];
  logic [IBUF_ENTRY_W-1:0] wdata [0:ENQ_W-1];
  logic [PTR_W-1:0]        raddr [0:DEQ_W-1];

  // free_slots looks only at registered occupancy, never at this cycle's dequeue
  always_comb begin
    room        = OCC_W'(DEPTH) - occupancy;
    free_slots  = (room > OCC_W'(ENQ_W)) ? 3'(ENQ_W) : room[2:0];
    accepted    = (enq_count > free_slots) ? free_slots : enq_count;
    valid_lanes = (occupancy >= OCC_W'(DEQ_W)) ? 2'(DEQ_W) : occupancy[1:0];
    consumed    = (deq_count > valid_lanes) ? valid_lanes : deq_count;
    occ_next    = occupancy + OCC_W'(accepted) - OCC_W'(consumed);
  end

  always_comb begin
    for (int i = 0; i < ENQ_W; i++) begin
      we[i]    = !rst && !flush && (3'(i) < accepted);
      waddr[i] = tail + PTR_W'(i);
      wdata[i] = enq_entry[i];
    end
    for (int i = 0; i < DEQ_W; i++) begin
      raddr[i]     = head + PTR_W'(i);
      out_valid[i] = occupancy > OCC_W'(i);
    end
  end

  // Reset wins over flush; flush keeps the sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + PTR_W'(consumed);
      tail      <= tail + PTR_W'(accepted);
      occupancy <= occ_next;
      if (enq_count > free_slots) overflow_err  <= 1'b1;
      if (deq_count > valid_lanes) underflow_err <= 1'b1;
    end
  end

`ifdef IBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      full_stall_cycles <= '0;
    end else if (occupancy == OCC_W'(DEPTH) && enq_count != 3'd0 &&
                 full_stall_cycles != 16'hFFFF) begin
      full_stall_cycles <= full_stall_cycles + 16'd1;
    end
  end
`endif

  ibuf_ram #(
    .DEPTH   (DEPTH),
    .WR_PORTS(ENQ_W),
    .RD_PORTS(DEQ_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(out_entry)
  );

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_instr_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [2:0]  enq_count;
  logic [29:0] enq_entry [0:3];
  logic [2:0]  free_slots;
  logic        out_valid [0:1];
  logic [29:0] out_entry [0:1];
  logic [1:0]  deq_count;
  logic        overflow_err, underflow_err;
`ifdef IBUF_STATS_EN
  logic [15:0] full_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is just an ordered queue of entries
  logic [29:0] q[$];
  bit          m_ovf, m_udf;
  int          m_stall;
  int          seq_op;

  always #5 clk = ~clk;

  instr_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq_count    (enq_count),
    .enq_entry    (enq_entry),
    .free_slots   (free_slots),
    .out_valid    (out_valid),
    .out_entry    (out_entry),
    .deq_count    (deq_count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
`ifdef IBUF_STATS_EN
    ,
    .full_stall_cycles(full_stall_cycles)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    int free;
    free = 16 - q.size();
    if (free > 4) free = 4;
    checkOutput({tag, "_free"}, 32'(free_slots), 32'(free));
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_valid"}, 32'(out_valid[i]), 32'(q.size() > i));
      if (q.size() > i) checkOutput({tag, "_entry"}, 32'(out_entry[i]), 32'(q[i]));
    end
    checkOutput({tag, "_ovf"}, 32'(overflow_err), 32'(m_ovf));
    checkOutput({tag, "_udf"}, 32'(underflow_err), 32'(m_udf));
`ifdef IBUF_STATS_EN
    checkOutput({tag, "_stall"}, 32'(full_stall_cycles), 32'(m_stall));
`endif
  endtask

  // Called at a negedge: drive one cycle, advance the model, check after the edge
  task automatic applyStimulus(input string tag, input int n_enq, input int n_deq,
                               input bit do_flush, input bit do_rst);
    int free, acc, vld, cons;
    logic [29:0] lane [0:3];
    rst       = do_rst;
    flush     = do_flush;
    enq_count = 3'(n_enq);
    deq_count = 2'(n_deq);
    for (int i = 0; i < 4; i++) begin
      lane[i]      = {4'(seq_op + i), 26'($urandom)};
      enq_entry[i] = lane[i];
    end
    seq_op += n_enq;

    free = 16 - q.size();
    if (free > 4) free = 4;
    if (do_rst) m_stall = 0;
    else if (q.size() == 16 && n_enq != 0 && m_stall < 65535) m_stall++;

    if (do_rst) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else if (do_flush) begin
      q.delete();
    end else begin
      acc  = (n_enq > free) ? free : n_enq;
      vld  = (q.size() > 2) ? 2 : q.size();
      cons = (n_deq > vld) ? vld : n_deq;
      if (n_enq > free) m_ovf = 1;
      if (n_deq > vld) m_udf = 1;
      for (int i = 0; i < cons; i++) void'(q.pop_front());
      for (int i = 0; i < acc; i++) q.push_back(lane[i]);
    end

    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    enq_count = 3'd0;
    deq_count = 2'd0;
    checkModel(tag);
  endtask

  initial begin
    int n_enq, n_deq, lim;
    rst = 1'b1;
    flush = 1'b0;
    enq_count = 3'd0;
    deq_count = 2'd0;
    for (int i = 0; i < 4; i++) enq_entry[i] = '0;
    m_ovf = 0;
    m_udf = 0;
    m_stall = 0;
    seq_op = 0;
    @(negedge clk);

    // Reset with an in-flight enqueue that must be dropped
    applyStimulus("reset", 4, 0, 0, 1);
    checkOutput("reset_free", 32'(free_slots), 32'd4);
    checkOutput("reset_valid0", 32'(out_valid[0]), 32'd0);

    // First four entries, opcodes 0..3
    seq_op = 0;
    applyStimulus("enq4", 4, 0, 0, 0);
    checkOutput("enq4_op0", 32'(out_entry[0][29:26]), 32'd0);
    checkOutput("enq4_op1", 32'(out_entry[1][29:26]), 32'd1);
    checkOutput("enq4_free", 32'(free_slots), 32'd4);

    // Fill to DEPTH, then overflow
    for (int c = 0; c < 3; c++) applyStimulus("fill", 4, 0, 0, 0);
    checkOutput("full_free", 32'(free_slots), 32'd0);
    applyStimulus("ovf", 4, 0, 0, 0);
    checkOutput("ovf_flag", 32'(overflow_err), 32'd1);
`ifdef IBUF_STATS_EN
    for (int c = 0; c < 4; c++) applyStimulus("stall", 4, 0, 0, 0);
    checkOutput("stall_5", 32'(full_stall_cycles), 32'd5);
`endif

    // Occupancy DEPTH-1 and DEPTH-3 boundaries
    applyStimulus("deq1", 0, 1, 0, 0);
    checkOutput("occ15_free", 32'(free_slots), 32'd1);
    applyStimulus("deq2", 0, 2, 0, 0);
    checkOutput("occ13_free", 32'(free_slots), 32'd3);

    // Wrap-around ordering: move pointers to 2, fill 14, then stream 2-in/2-out
    applyStimulus("rst2", 0, 0, 0, 1);
`ifdef IBUF_STATS_EN
    checkOutput("stall_rst", 32'(full_stall_cycles), 32'd0);
`endif
    applyStimulus("pre", 2, 0, 0, 0);
    applyStimulus("pre", 0, 2, 0, 0);
    applyStimulus("pre", 4, 0, 0, 0);
    applyStimulus("pre", 4, 0, 0, 0);
    applyStimulus("pre", 4, 0, 0, 0);
    applyStimulus("pre", 2, 0, 0, 0);
    for (int c = 0; c < 10; c++) applyStimulus("wrap", 2, 2, 0, 0);

    // Underflow from occupancy 1
    applyStimulus("rst3", 0, 0, 0, 1);
    applyStimulus("one", 1, 0, 0, 0);
    applyStimulus("udf", 0, 2, 0, 0);
    checkOutput("udf_flag", 32'(underflow_err), 32'd1);
    checkOutput("udf_valid0", 32'(out_valid[0]), 32'd0);

    // Flush with concurrent enqueue/dequeue from occupancy 8
    applyStimulus("rst4", 0, 0, 0, 1);
    applyStimulus("f8", 4, 0, 0, 0);
    applyStimulus("f8", 4, 0, 0, 0);
    applyStimulus("flush", 4, 2, 1, 0);
    checkOutput("flush_valid0", 32'(out_valid[0]), 32'd0);
    checkOutput("flush_free", 32'(free_slots), 32'd4);
    applyStimulus("postflush", 3, 0, 0, 0);

    // Randomized traffic, mostly legal dequeues
    for (int c = 0; c < 400; c++) begin
      n_enq = $urandom_range(0, 4);
      n_deq = $urandom_range(0, 2);
      lim = (q.size() > 2) ? 2 : q.size();
      if ($urandom_range(0, 9) != 0 && n_deq > lim) n_deq = lim;
      applyStimulus("rand", n_enq, n_deq, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Circular instruction buffer between instruction fetch/decode and dispatch. Each cycle it accepts up to 4 decoded instructions (opcode, register fields, local-dependency owner tags, unit-class flags) and presents the 2 oldest to dispatch. It reports free space back to fetch so fetch never over-issues. It is emptied on a taken jump.

## Interface
Parameters:
- DEPTH, 16, entries; power of two, ≥ 8.
- ENQ_W, 4, enqueue lanes, matching fetch width.
- DEQ_W, 2, dequeue lanes presented to dispatch.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  taken jump; empty the buffer.
- enq_count  in  3  number of valid enqueue lanes, 0..4; always lanes 0..enq_count-1.
- enq_entry[0:3]  in  30  packed ibuf_entry_t per lane: opcode 4, rt 4, ra 4, rb 4, op_a_local_dep 1, op_a_owner 4, op_b_local_dep 1, op_b_owner 4, uses_rb 1, is_ld_str 1, is_fxu 1, is_branch 1.
- free_slots  out  3  min(DEPTH − occupancy, 4); fetch's num_fetch for the next cycle.
- out_valid[0:1]  out  1  lane holds a valid entry (lane 1 valid implies lane 0 valid).
- out_entry[0:1]  out  30  oldest entries, lane 0 oldest.
- deq_count  in  2  entries consumed by dispatch this cycle, 0..2.
- overflow_err  out  1  sticky: enq_count exceeded free_slots.
- underflow_err  out  1  sticky: deq_count exceeded valid lanes.

## Operation
- State: head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (log2 DEPTH + 1 bits), entry array.
- Enqueue: lane i is written at tail+i (mod DEPTH) for i < accepted; tail += accepted. accepted = min(enq_count, free_slots). Excess lanes are dropped and overflow_err is set.
- Dequeue: head += consumed, where consumed = min(deq_count, number of valid lanes). If deq_count exceeds valid lanes, underflow_err is set.
- Occupancy next = occupancy + accepted − consumed. Simultaneous enqueue and dequeue is legal in any combination.
- out_entry[i] = array[head+i] (mod DEPTH), read combinationally from registered state. out_valid[i] = (occupancy > i).
- Flush: head, tail and occupancy are cleared to 0. Same-cycle enqueue and dequeue are discarded. Error flags are not cleared.
- Reset overrides flush. After reset: head = tail = 0, occupancy = 0, out_valid = 0, free_slots = 4, overflow_err = 0, underflow_err = 0. Entry array contents are don't-care.
- Reset asserted mid-stream discards all contents. Any in-flight enqueue in that cycle is dropped.

## Timing
- Enqueue-to-visible latency is 1 cycle. An entry written at edge N appears on out_entry at edge N+1 at the earliest. There is no same-cycle bypass.
- free_slots is derived from registered occupancy only. It does not credit a same-cycle dequeue.
- Boundary cases:
  - Full (occupancy = DEPTH): free_slots = 0, and all enqueue lanes are dropped if enq_count ≠ 0.
  - Occupancy of DEPTH−1 or DEPTH−3: free_slots = 1 or 3 respectively.
  - Empty: out_valid = 00, and deq_count must be 0.
  - Wrap-around: a 4-lane enqueue starting at tail = DEPTH−2 writes entries DEPTH−2, DEPTH−1, 0, 1.
- Flush takes effect at the edge. On the next cycle: out_valid = 00 and free_slots = 4.

## Configuration
- IBUF_STATS_EN defined: adds output full_stall_cycles, 16 bits, saturating at 0xFFFF. It increments each cycle in which occupancy = DEPTH and enq_count ≠ 0. It is cleared by rst only.
- IBUF_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package ooo_pkg holds:
  - typedef ibuf_entry_t (packed, field order as listed in the interface, opcode in the MSBs);
  - constants FETCH_W = 4 and DISPATCH_W = 2;
  - opcode-class localparams.
- One sub-module, ibuf_ram: a DEPTH × 30 register array with 4 write ports and 2 combinational read ports, indexed by wrapped addresses. All pointer and occupancy logic stays in instr_buffer.

## Test plan
- Reset, then enqueue 4 entries (opcodes 0..3), deq_count = 0 → next cycle: out_valid = 11, out_entry opcodes 0 and 1, free_slots = 4.
- Continuous enqueue of 4 per cycle, no dequeue → after 4 cycles: free_slots = 0, occupancy = 16. A 5th enqueue is dropped with overflow_err = 1, and contents are unchanged.
- Pre-fill 14 entries (head = tail = 2 via earlier dequeues), then enqueue 2 + dequeue 2 per cycle for 10 cycles → output order is preserved across the index 15 → 0 wrap.
- Occupancy 1, then deq_count = 2 → underflow_err = 1, occupancy 0, out_valid = 00.
- Occupancy 8, then flush together with enq_count = 4 and deq_count = 2 → next cycle: out_valid = 00, free_slots = 4, tail = 0.
- With IBUF_STATS_EN: hold buffer full with enq_count = 4 for 5 cycles → full_stall_cycles = 5. rst → 0.
